// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: keeps the PC, issues in-order word fetches under a credit limit,
// and buffers returned instructions with their PCs for decode. Redirects flush and drop stale responses.
module if_fetch_unit #(
  parameter int                WORD_W   = 32,
  parameter int                INSTR_W  = 32,
  parameter logic [WORD_W-1:0] RESET_PC = '0,
  parameter int                DEPTH    = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               o_imem_req_valid,
  input  logic               i_imem_req_ready,
  output logic [WORD_W-1:0]  o_imem_req_addr,
  input  logic               i_imem_resp_valid,
  input  logic [INSTR_W-1:0] i_imem_resp_data,
  output logic               o_instr_valid,
  output logic [INSTR_W-1:0] o_instr,
  output logic [WORD_W-1:0]  o_instr_pc,
  input  logic               i_id_ready,
  input  logic               i_redirect_valid,
  input  logic [WORD_W-1:0]  i_redirect_pc
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

  logic [WORD_W-1:0]  r_pc;
  logic [WORD_W-1:0]  r_resp_pc;
  logic [INSTR_W-1:0] r_instr_mem [DEPTH];
  logic [WORD_W-1:0]  r_pc_mem    [DEPTH];
  logic [AW-1:0]      r_wr_ptr;
  logic [AW-1:0]      r_rd_ptr;
  logic [CW-1:0]      r_count;
  logic [CW-1:0]      r_inflight;
  logic [CW-1:0]      r_drop;

  logic              w_req_fire;
  logic              w_push;
  logic              w_pop;
  logic [CW:0]       w_credit_used;
  logic [CW-1:0]     w_outstanding;
  logic [WORD_W-1:0] w_redirect_pc;

  // Outputs are qualified by rst_n so the reset cycle itself already shows an idle stage.
  assign w_credit_used    = {1'b0, r_inflight} + {1'b0, r_count};
  assign o_imem_req_valid = rst_n && (w_credit_used < DEPTH_C);
  assign o_imem_req_addr  = r_pc;
  assign o_instr_valid    = rst_n && (r_count != '0);
  assign o_instr          = o_instr_valid ? r_instr_mem[r_rd_ptr] : '0;
  assign o_instr_pc       = o_instr_valid ? r_pc_mem[r_rd_ptr] : '0;

  assign w_req_fire    = o_imem_req_valid & i_imem_req_ready;
  assign w_push        = i_imem_resp_valid & ~i_redirect_valid & (r_drop == '0);
  assign w_pop         = o_instr_valid & i_id_ready & ~i_redirect_valid;
  assign w_outstanding = r_inflight + CW'(w_req_fire) - CW'(i_imem_resp_valid);
  assign w_redirect_pc = i_redirect_pc & ~WORD_W'(3);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc       <= RESET_PC;
      r_resp_pc  <= RESET_PC;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_inflight <= '0;
      r_drop     <= '0;
    end else begin
      r_inflight <= w_outstanding;
      if (i_redirect_valid) begin
        // Everything still outstanding after this edge belongs to the old path.
        r_pc      <= w_redirect_pc;
        r_resp_pc <= w_redirect_pc;
        r_drop    <= w_outstanding;
        r_wr_ptr  <= '0;
        r_rd_ptr  <= '0;
        r_count   <= '0;
      end else begin
        if (w_req_fire) begin
          r_pc <= r_pc + WORD_W'(4);
        end
        if (i_imem_resp_valid && (r_drop != '0)) begin
          r_drop <= r_drop - CW'(1);
        end
        if (w_push) begin
          r_wr_ptr  <= r_wr_ptr + AW'(1);
          r_resp_pc <= r_resp_pc + WORD_W'(4);
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + AW'(1);
        end
        r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
    end
  end

  // NOTE: FIFO storage has no reset; r_count gates every read, so stale contents are never visible.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_instr_mem[r_wr_ptr] <= i_imem_resp_data;
      r_pc_mem[r_wr_ptr]    <= r_resp_pc;
    end
  end

  a_no_orphan_resp : assert property (@(posedge clk) disable iff (!rst_n)
    i_imem_resp_valid |-> (r_inflight != '0));

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed scenarios plus random traffic against a stream-level model
// (decode must see a contiguous PC run from the last redirect; credit = pending fetches + buffered words).
module tb_if_fetch_unit;

  localparam int          DEPTH   = 4;
  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, resp_valid, instr_valid, id_ready, rd_valid;
  logic [31:0] req_addr, resp_data, instr, instr_pc, rd_pc;
  logic        wr_req_valid, wr_resp_valid, wr_instr_valid;
  logic [31:0] wr_req_addr, wr_resp_data, wr_instr, wr_instr_pc;

  always #5 clk = ~clk;

  if_fetch_unit #(.WORD_W(32), .INSTR_W(32), .RESET_PC(32'h0), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .o_imem_req_valid(req_valid), .i_imem_req_ready(req_ready), .o_imem_req_addr(req_addr),
    .i_imem_resp_valid(resp_valid), .i_imem_resp_data(resp_data),
    .o_instr_valid(instr_valid), .o_instr(instr), .o_instr_pc(instr_pc), .i_id_ready(id_ready),
    .i_redirect_valid(rd_valid), .i_redirect_pc(rd_pc)
  );

  if_fetch_unit #(.WORD_W(32), .INSTR_W(32), .RESET_PC(WRAP_PC), .DEPTH(2)) dut_wrap (
    .clk(clk), .rst_n(rst_n),
    .o_imem_req_valid(wr_req_valid), .i_imem_req_ready(1'b1), .o_imem_req_addr(wr_req_addr),
    .i_imem_resp_valid(wr_resp_valid), .i_imem_resp_data(wr_resp_data),
    .o_instr_valid(wr_instr_valid), .o_instr(wr_instr), .o_instr_pc(wr_instr_pc), .i_id_ready(1'b1),
    .i_redirect_valid(1'b0), .i_redirect_pc(32'h0)
  );

  int          total = 0;
  int          bad   = 0;
  logic [31:0] q_addr [$];
  int          q_epoch [$];
  int          epoch    = 0;
  int          m_count  = 0;
  logic [31:0] m_next_req = 32'h0;
  logic [31:0] m_exp_pc   = 32'h0;
  int          mem_en   = 1;
  int          resp_pct = 100;
  logic        s_req_valid, s_instr_valid, s_pop;
  logic [31:0] s_addr, s_pop_pc;
  logic        w_hs;
  logic [31:0] w_addr;
  logic [31:0] w_addr_log [$];
  logic [31:0] w_pc_log [$];
  logic [31:0] w_instr_log [$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A3C_96E1;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: sample and compare at negedge, advance the model at posedge, then drive memory.
  task automatic step();
    logic        m_valid, hs, rsp, pop, rd;
    logic [31:0] tgt;
    int          e;
    @(negedge clk);
    m_valid = rst_n && ((q_addr.size() + m_count) < DEPTH);
    check("req_valid", 32'(req_valid), 32'(m_valid));
    check("instr_valid", 32'(instr_valid), 32'(rst_n && (m_count != 0)));
    if (m_valid) check("req_addr", req_addr, m_next_req);
    if (!rst_n) begin
      check("rst_instr", instr, 32'h0);
      check("rst_instr_pc", instr_pc, 32'h0);
    end
    rd  = rst_n && rd_valid;
    tgt = rd_pc & ~32'h3;
    hs  = m_valid && req_ready;
    rsp = rst_n && resp_valid;
    pop = rst_n && (m_count != 0) && id_ready && !rd_valid;
    if (pop) begin
      check("instr_pc", instr_pc, m_exp_pc);
      check("instr", instr, mem_word(m_exp_pc));
    end
    s_req_valid   = req_valid;
    s_instr_valid = instr_valid;
    s_addr        = req_addr;
    s_pop         = pop;
    s_pop_pc      = instr_pc;
    w_hs          = wr_req_valid;
    w_addr        = wr_req_addr;
    if (w_hs && w_addr_log.size() < 3) w_addr_log.push_back(wr_req_addr);
    if (wr_instr_valid && w_pc_log.size() < 3) begin
      w_pc_log.push_back(wr_instr_pc);
      w_instr_log.push_back(wr_instr);
    end
    @(posedge clk);
    if (!rst_n) begin
      q_addr.delete();
      q_epoch.delete();
      m_count    = 0;
      m_next_req = 32'h0;
      m_exp_pc   = 32'h0;
      epoch++;
    end else begin
      if (hs) begin
        q_addr.push_back(m_next_req);
        q_epoch.push_back(epoch);
        m_next_req += 32'h4;
      end
      if (rsp && q_addr.size() > 0) begin
        e = q_epoch.pop_front();
        void'(q_addr.pop_front());
        if (e == epoch && !rd) m_count++;
      end
      if (pop) begin
        m_count--;
        m_exp_pc += 32'h4;
      end
      if (rd) begin
        m_count    = 0;
        epoch++;
        m_next_req = tgt;
        m_exp_pc   = tgt;
      end
    end
    #1;
    if (rst_n && mem_en != 0 && q_addr.size() > 0 && int'($urandom_range(99)) < resp_pct) begin
      resp_valid = 1'b1;
      resp_data  = mem_word(q_addr[0]);
    end else begin
      resp_valid = 1'b0;
      resp_data  = 32'h0;
    end
    wr_resp_valid = w_hs && rst_n;
    wr_resp_data  = mem_word(w_addr);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: sim time %0t exceeded limit 500000", $time);
    $fatal(1, "bench timed out");
  end

  initial begin
    logic        found;
    logic [31:0] first_pc;
    logic [31:0] exp_w [3];
    rst_n = 1'b0; req_ready = 1'b0; id_ready = 1'b0; rd_valid = 1'b0; rd_pc = 32'h0;
    resp_valid = 1'b0; resp_data = 32'h0; wr_resp_valid = 1'b0; wr_resp_data = 32'h0;

    // Reset state
    step();
    step();
    check("rst_addr", s_addr, 32'h0);
    check("rst_req_valid", 32'(s_req_valid), 32'h0);
    check("rst_out_valid", 32'(s_instr_valid), 32'h0);

    // Start-up stream: always-ready memory with 1-cycle response
    rst_n = 1'b1; req_ready = 1'b1; id_ready = 1'b1;
    step(); check("c0_req_valid", 32'(s_req_valid), 32'h1); check("c0_addr", s_addr, 32'h0);
    step(); check("c1_addr", s_addr, 32'h4);
    step(); check("c2_valid", 32'(s_instr_valid), 32'h1); check("c2_pc", s_pop_pc, 32'h0);
    step(); check("c3_pc", s_pop_pc, 32'h4);
    step(); check("c4_pc", s_pop_pc, 32'h8);

    // Decode stall: credit limit stops fetching, then drain in order
    id_ready = 1'b0;
    for (int i = 0; i < 12; i++) step();
    check("stall_req_valid", 32'(s_req_valid), 32'h0);
    check("stall_out_valid", 32'(s_instr_valid), 32'h1);
    id_ready = 1'b1;
    for (int i = 0; i < 12; i++) step();

    // Memory not ready for 3 cycles: address held at 0x10
    req_ready = 1'b0; rd_valid = 1'b1; rd_pc = 32'h10;
    step();
    rd_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("hold_addr", s_addr, 32'h10);
      check("hold_valid", 32'(s_req_valid), 32'h1);
    end
    req_ready = 1'b1;
    step();
    step(); check("hold_next_addr", s_addr, 32'h14);

    // Redirect with two fetches (0x20, 0x24) in flight
    req_ready = 1'b0;
    for (int i = 0; i < 20 && q_addr.size() > 0; i++) step();
    mem_en = 0; rd_valid = 1'b1; rd_pc = 32'h20;
    step();
    rd_valid = 1'b0; req_ready = 1'b1;
    step(); check("fl_addr0", s_addr, 32'h20); check("fl_valid0", 32'(s_req_valid), 32'h1);
    step(); check("fl_addr1", s_addr, 32'h24);
    req_ready = 1'b0; rd_valid = 1'b1; rd_pc = 32'h103;
    step();
    rd_valid = 1'b0; mem_en = 1;
    step(); check("rd_addr", s_addr, 32'h100); check("rd_req_valid", 32'(s_req_valid), 32'h1);
    req_ready = 1'b1;
    found = 1'b0; first_pc = 32'h0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (s_pop) begin
        found    = 1'b1;
        first_pc = s_pop_pc;
      end
    end
    check("rd_pop_seen", 32'(found), 32'h1);
    check("rd_first_pc", first_pc, 32'h100);

    // Reset for one cycle with the FIFO full
    id_ready = 1'b0;
    for (int i = 0; i < 12; i++) step();
    check("full_req_valid", 32'(s_req_valid), 32'h0);
    rst_n = 1'b0; resp_valid = 1'b0; wr_resp_valid = 1'b0;
    step();
    check("mrst_out_valid", 32'(s_instr_valid), 32'h0);
    check("mrst_req_valid", 32'(s_req_valid), 32'h0);
    rst_n = 1'b1;
    step();
    check("mrst_req_again", 32'(s_req_valid), 32'h1);
    check("mrst_addr", s_addr, 32'h0);

    // Random traffic: back-pressure on both sides, variable memory latency, random redirects
    resp_pct = 60;
    for (int i = 0; i < 3000; i++) begin
      req_ready = ($urandom_range(99) < 75);
      id_ready  = ($urandom_range(99) < 70);
      rd_valid  = ($urandom_range(99) < 4);
      rd_pc     = $urandom;
      step();
    end
    rd_valid = 1'b0; req_ready = 1'b1; id_ready = 1'b1; resp_pct = 100;
    for (int i = 0; i < 30; i++) step();

    // Wrap-around instance (RESET_PC = 0xFFFFFFF8)
    exp_w[0] = WRAP_PC; exp_w[1] = 32'hFFFF_FFFC; exp_w[2] = 32'h0;
    check("wrap_addr_n", 32'(w_addr_log.size()), 32'd3);
    check("wrap_pc_n", 32'(w_pc_log.size()), 32'd3);
    for (int i = 0; i < 3; i++) begin
      if (i < w_addr_log.size()) check("wrap_addr", w_addr_log[i], exp_w[i]);
      if (i < w_pc_log.size()) begin
        check("wrap_pc", w_pc_log[i], exp_w[i]);
        check("wrap_instr", w_instr_log[i], mem_word(exp_w[i]));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
